// File: rtl/xtal_32k_monitor.sv
// xtal_32k_monitor
// Supervisor for the 32.768 kHz crystal oscillator macro. It sequences
// enable/boost, measures each 32k period in clk cycles, and reports a
// per-edge tick, lock and fault to the always-on timer logic.
//
// Optional build macro: XTAL_MON_AUTORESTART_EN
//   defined   : FAULT holds the oscillator off for EDGE_TIMEOUT cycles and
//               then retries start-up.
//   undefined : FAULT is sticky until en drops or rst is asserted.
module xtal_32k_monitor #(
  parameter int CNT_W        = 12,
  parameter int PERIOD_MIN   = 296,
  parameter int PERIOD_MAX   = 328,
  parameter int EDGE_TIMEOUT = 1024,
  parameter int LOCK_EDGES   = 16,
  parameter int STARTUP_CYC  = 4000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             xtal_dout,
  output logic             xtal_ena,
  output logic             xtal_boost,
  output logic             tick,
  output logic             ok,
  output logic             fault,
  output logic [CNT_W-1:0] period,
  output logic [1:0]       state
);

  localparam int GOOD_W = $clog2(LOCK_EDGES + 1);

  localparam logic [CNT_W-1:0]  CNT_ONES   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  LOSS_AT    = CNT_W'(EDGE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  PMIN       = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0]  PMAX       = CNT_W'(PERIOD_MAX);
  localparam logic [23:0]       START_LAST = 24'(STARTUP_CYC - 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK  = GOOD_W'(LOCK_EDGES);
`ifdef XTAL_MON_AUTORESTART_EN
  localparam logic [23:0]       HOLD_LAST  = 24'(EDGE_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_LOCK  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // synchronizer / edge detect
  logic sync1_r, sync2_r, dly_r;
  logic tk_s;

  // period measurement
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] period_r;
  logic             armed_r;
  logic             measure_s;
  logic             in_win_s;
  logic             loss_s;

  // state machine
  state_t            state_r, state_nxt_s, st_fsm_s;
  logic [GOOD_W-1:0] good_r, good_nxt_s, good_inc_s;
  logic [23:0]       timer_r, timer_nxt_s;
  logic              clr_fsm_s, clr_s;

  // registered outputs
  logic tick_r, ok_r, fault_r, ena_r, boost_r;
  logic ok_nxt_s, fault_nxt_s, ena_nxt_s, boost_nxt_s;

  // Rising edge of the synchronized oscillator output.
  assign tk_s = sync2_r & ~dly_r;

  // Counter+1 with saturation; this is also the period measured on a tick.
  assign cnt_inc_s = (cnt_r == CNT_ONES) ? CNT_ONES : (cnt_r + CNT_W'(1));

  // Only ticks after the arming tick carry a valid measurement.
  assign measure_s = tk_s & armed_r;
  assign in_win_s  = (cnt_inc_s >= PMIN) && (cnt_inc_s <= PMAX);

  // A tick in the same cycle as the timeout point cancels the loss.
  assign loss_s    = (cnt_r == LOSS_AT) && !tk_s;

  assign good_inc_s = good_r + GOOD_W'(1);

  // Two-flop synchronizer followed by the edge-detect delay flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      dly_r   <= 1'b0;
    end else begin
      sync1_r <= xtal_dout;
      sync2_r <= sync1_r;
      dly_r   <= sync2_r;
    end
  end

  // Free-running period counter, cleared on each tick and on start-up entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      armed_r <= 1'b0;
    end else if (clr_s) begin
      cnt_r   <= {CNT_W{1'b0}};
      armed_r <= 1'b0;
    end else if (tk_s) begin
      cnt_r   <= {CNT_W{1'b0}};
      armed_r <= 1'b1;
    end else begin
      cnt_r   <= cnt_inc_s;
      armed_r <= armed_r;
    end
  end

  // Capture the measured period; the value is frozen while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_r <= {CNT_W{1'b0}};
    end else if (measure_s && (state_r != ST_IDLE)) begin
      period_r <= cnt_inc_s;
    end else begin
      period_r <= period_r;
    end
  end

  // Next-state logic; dropping en overrides every other transition.
  always_comb begin
    st_fsm_s    = state_r;
    good_nxt_s  = good_r;
    timer_nxt_s = timer_r;
    clr_fsm_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          st_fsm_s    = ST_START;
          clr_fsm_s   = 1'b1;
          good_nxt_s  = {GOOD_W{1'b0}};
          timer_nxt_s = 24'd0;
        end else begin
          st_fsm_s    = ST_IDLE;
        end
      end
      ST_START: begin
        timer_nxt_s = timer_r + 24'd1;
        if (measure_s && in_win_s) begin
          good_nxt_s = good_inc_s;
        end else if (measure_s) begin
          good_nxt_s = {GOOD_W{1'b0}};
        end else begin
          good_nxt_s = good_r;
        end
        if (measure_s && in_win_s && (good_inc_s == GOOD_LOCK)) begin
          st_fsm_s    = ST_LOCK;
        end else if (timer_r == START_LAST) begin
          // timer doubles as the restart holdoff counter in FAULT
          st_fsm_s    = ST_FAULT;
          timer_nxt_s = 24'd0;
        end else begin
          st_fsm_s    = ST_START;
        end
      end
      ST_LOCK: begin
        if ((measure_s && !in_win_s) || loss_s) begin
          st_fsm_s    = ST_FAULT;
          timer_nxt_s = 24'd0;
        end else begin
          st_fsm_s    = ST_LOCK;
        end
      end
      ST_FAULT: begin
`ifdef XTAL_MON_AUTORESTART_EN
        if (timer_r == HOLD_LAST) begin
          st_fsm_s    = ST_START;
          clr_fsm_s   = 1'b1;
          good_nxt_s  = {GOOD_W{1'b0}};
          timer_nxt_s = 24'd0;
        end else begin
          st_fsm_s    = ST_FAULT;
          timer_nxt_s = timer_r + 24'd1;
        end
`else
        st_fsm_s = ST_FAULT;
`endif
      end
      default: begin
        st_fsm_s = ST_IDLE;
      end
    endcase

    if (!en) begin
      state_nxt_s = ST_IDLE;
      clr_s       = 1'b0;
    end else begin
      state_nxt_s = st_fsm_s;
      clr_s       = clr_fsm_s;
    end
  end

  // Output decode from the next state so outputs change with state.
  always_comb begin
    ok_nxt_s    = 1'b0;
    fault_nxt_s = 1'b0;
    ena_nxt_s   = 1'b0;
    boost_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        ena_nxt_s   = 1'b0;
      end
      ST_START: begin
        ena_nxt_s   = 1'b1;
        boost_nxt_s = 1'b1;
      end
      ST_LOCK: begin
        ena_nxt_s   = 1'b1;
        ok_nxt_s    = 1'b1;
      end
      ST_FAULT: begin
        fault_nxt_s = 1'b1;
`ifdef XTAL_MON_AUTORESTART_EN
        ena_nxt_s   = 1'b0;
`else
        ena_nxt_s   = 1'b1;
`endif
      end
      default: begin
        ena_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, good-edge count and start-up/holdoff timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      good_r  <= {GOOD_W{1'b0}};
      timer_r <= 24'd0;
    end else begin
      state_r <= state_nxt_s;
      good_r  <= good_nxt_s;
      timer_r <= timer_nxt_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r  <= 1'b0;
      ok_r    <= 1'b0;
      fault_r <= 1'b0;
      ena_r   <= 1'b0;
      boost_r <= 1'b0;
    end else begin
      tick_r  <= tk_s;
      ok_r    <= ok_nxt_s;
      fault_r <= fault_nxt_s;
      ena_r   <= ena_nxt_s;
      boost_r <= boost_nxt_s;
    end
  end

  assign tick       = tick_r;
  assign ok         = ok_r;
  assign fault      = fault_r;
  assign xtal_ena   = ena_r;
  assign xtal_boost = boost_r;
  assign period     = period_r;
  assign state      = state_r;

endmodule
